// File: rtl/chan_debug_bridge_if.sv
// Channel pipe bundle between comm_fpga_fx2 (master) and chan_debug_bridge (slave).
// Member names follow the bridge-side port names so both ends read the same.
interface chan_debug_bridge_if;
  logic [6:0] chanAddr_in;
  logic [7:0] h2fData_in;
  logic       h2fValid_in;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in;

  modport master (
    output chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
    input  h2fReady_out, f2hData_out, f2hValid_out
  );

  modport slave (
    input  chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
    output h2fReady_out, f2hData_out, f2hValid_out
  );
endinterface

// File: rtl/chan_debug_bridge.sv
// Register-mapped debug port: coherent snapshot of CPU test signals, run/halt/step
// control and auto-incrementing host access to program RAM while the CPU is halted.
module chan_debug_bridge #(
  parameter int         NUM_DBG    = 8,
  parameter int         ADDR_W     = 16,
  parameter logic [6:0] CTRL_CH    = 7'h40,
  parameter logic [6:0] ADDR_LO_CH = 7'h41,
  parameter logic [6:0] ADDR_HI_CH = 7'h42,
  parameter logic [6:0] MEM_CH     = 7'h43
) (
  input  logic                   clk,
  input  logic                   reset,
  chan_debug_bridge_if.slave     chan,
  input  logic [NUM_DBG*8-1:0]   dbg_in,
  output logic                   cpu_run_out,
  output logic                   cpu_step_out,
  output logic                   ram_host_sel_out,
  output logic [ADDR_W-1:0]      ram_addr_out,
  output logic [7:0]             ram_din_out,
  output logic                   ram_we_out,
  input  logic [7:0]             ram_dout_in,
  output logic [7:0]             led_out
);

  localparam int IDX_W = (NUM_DBG > 1) ? $clog2(NUM_DBG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  fetch_state_t              state_r, state_nx_s;
  logic                      run_r, step_r, cap_r, ram_we_r;
  logic [NUM_DBG-1:0][7:0]   snap_r;
  logic [ADDR_W-1:0]         ptr_r, wr_addr_r;
  logic [7:0]                rd_buf_r, ram_din_r;
  logic                      ctrl_wr_s, lo_wr_s, hi_wr_s, mem_wr_s;
  logic                      run_rise_s, step_req_s, mem_sel_s, consume_s, abort_s;
  logic [15:0]               ptr_ext_s, ptr_lo_new_s, ptr_hi_new_s;
  logic [IDX_W-1:0]          dbg_idx_s;
  logic [7:0]                f2h_data_s;
  logic                      f2h_valid_s;

  assign ctrl_wr_s  = chan.h2fValid_in && (chan.chanAddr_in == CTRL_CH);
  assign lo_wr_s    = chan.h2fValid_in && (chan.chanAddr_in == ADDR_LO_CH);
  assign hi_wr_s    = chan.h2fValid_in && (chan.chanAddr_in == ADDR_HI_CH);
  assign mem_wr_s   = chan.h2fValid_in && (chan.chanAddr_in == MEM_CH) && !run_r;
  assign run_rise_s = ctrl_wr_s && chan.h2fData_in[0] && !run_r;
  // A step is only meaningful when the CPU stays halted across the write.
  assign step_req_s = ctrl_wr_s && chan.h2fData_in[1] && !chan.h2fData_in[0] && !run_r;
  assign mem_sel_s  = (chan.chanAddr_in == MEM_CH) && !run_r;
  assign abort_s    = !mem_sel_s || lo_wr_s || hi_wr_s || mem_wr_s || run_rise_s;

  // Pointer viewed as 16 bits so the high byte reads 0 above ADDR_W.
  assign ptr_ext_s    = 16'(ptr_r);
  assign ptr_lo_new_s = {ptr_ext_s[15:8], chan.h2fData_in};
  assign ptr_hi_new_s = {chan.h2fData_in, ptr_ext_s[7:0]};
  assign dbg_idx_s    = chan.chanAddr_in[IDX_W-1:0];

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Fetch FSM next-state and read-consumption decode.
  always_comb begin
    state_nx_s = state_r;
    consume_s  = 1'b0;
    if (abort_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx_s = ST_FETCH;
        ST_FETCH: state_nx_s = ST_VALID;
        ST_VALID: begin
          if (chan.f2hReady_in) begin
            state_nx_s = ST_IDLE;
            consume_s  = 1'b1;
          end else begin
            state_nx_s = ST_VALID;
          end
        end
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Control, snapshot, pointer and RAM write registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r     <= 1'b0;
      step_r    <= 1'b0;
      cap_r     <= 1'b0;
      snap_r    <= '0;
      ptr_r     <= '0;
      wr_addr_r <= '0;
      ram_we_r  <= 1'b0;
      ram_din_r <= 8'h00;
      rd_buf_r  <= 8'h00;
    end else begin
      if (ctrl_wr_s) begin
        run_r <= chan.h2fData_in[0];
      end
      step_r   <= step_req_s;
      cap_r    <= ctrl_wr_s && chan.h2fData_in[2];
      ram_we_r <= mem_wr_s;
      if (mem_wr_s) begin
        wr_addr_r <= ptr_r;
        ram_din_r <= chan.h2fData_in;
      end
      if (cap_r || step_r) begin
        snap_r <= dbg_in;
      end
      if (lo_wr_s) begin
        ptr_r <= ADDR_W'(ptr_lo_new_s);
      end else if (hi_wr_s) begin
        ptr_r <= ADDR_W'(ptr_hi_new_s);
      end else if (mem_wr_s || consume_s) begin
        ptr_r <= ptr_r + ADDR_W'(1);
      end
      if ((state_r == ST_FETCH) && (state_nx_s == ST_VALID)) begin
        rd_buf_r <= ram_dout_in;
      end
    end
  end

  // Host read mux; debug channels only ever see the snapshot.
  always_comb begin
    f2h_data_s  = 8'h00;
    f2h_valid_s = 1'b1;
    if (chan.chanAddr_in < 7'(NUM_DBG)) begin
      f2h_data_s = snap_r[dbg_idx_s];
    end else begin
      case (chan.chanAddr_in)
        CTRL_CH:    f2h_data_s = {5'b00000, (state_r != ST_IDLE), step_r, run_r};
        ADDR_LO_CH: f2h_data_s = ptr_ext_s[7:0];
        ADDR_HI_CH: f2h_data_s = ptr_ext_s[15:8];
        MEM_CH: begin
          if (run_r) begin
            f2h_data_s = 8'hEE;
          end else begin
            f2h_data_s  = rd_buf_r;
            f2h_valid_s = (state_r == ST_VALID);
          end
        end
        default:    f2h_data_s = 8'h00;
      endcase
    end
  end

  assign chan.h2fReady_out = 1'b1;
  assign chan.f2hData_out  = f2h_data_s;
  assign chan.f2hValid_out = f2h_valid_s;
  assign cpu_run_out       = run_r;
  assign cpu_step_out      = step_r;
  assign ram_host_sel_out  = ~run_r;
  assign ram_we_out        = ram_we_r;
  assign ram_din_out       = ram_din_r;
  // Write address is held for the write cycle; otherwise the pointer drives fetches.
  assign ram_addr_out      = ram_we_r ? wr_addr_r : ptr_r;
  assign led_out           = snap_r[0];

endmodule

// File: tb/tb_chan_debug_bridge.sv
// Directed bench for chan_debug_bridge with a synchronous-read RAM model.
module tb_chan_debug_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] dbg_in;
  logic        cpu_run_out, cpu_step_out, ram_host_sel_out, ram_we_out;
  logic [15:0] ram_addr_out;
  logic [7:0]  ram_din_out, ram_dout_in, led_out;
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          failures = 0;

  chan_debug_bridge_if ch();

  chan_debug_bridge dut (
    .clk              (clk),
    .reset            (reset),
    .chan             (ch),
    .dbg_in           (dbg_in),
    .cpu_run_out      (cpu_run_out),
    .cpu_step_out     (cpu_step_out),
    .ram_host_sel_out (ram_host_sel_out),
    .ram_addr_out     (ram_addr_out),
    .ram_din_out      (ram_din_out),
    .ram_we_out       (ram_we_out),
    .ram_dout_in      (ram_dout_in),
    .led_out          (led_out)
  );

  always #5 clk = ~clk;

  // RAM model: data valid one clock after the address.
  always @(posedge clk) begin
    if (ram_we_out) mem[ram_addr_out] <= ram_din_out;
    ram_dout_in <= mem[ram_addr_out];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
    ch.chanAddr_in = a;
    ch.h2fData_in  = d;
    ch.h2fValid_in = 1'b1;
    tick();
    ch.h2fValid_in = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
    ch.chanAddr_in = a;
    #1;
    chk(tag, {24'h0, ch.f2hData_out}, {24'h0, exp});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset          = 1'b1;
    dbg_in         = 64'h0;
    ch.chanAddr_in = 7'h03;
    ch.h2fData_in  = 8'h00;
    ch.h2fValid_in = 1'b0;
    ch.f2hReady_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    rd("rst_ch3", 7'h03, 8'h00);
    chk("rst_h2f_ready", {31'h0, ch.h2fReady_out}, 32'h1);
    chk("rst_led", {24'h0, led_out}, 32'h0);
    chk("rst_run", {31'h0, cpu_run_out}, 32'h0);
    chk("rst_step", {31'h0, cpu_step_out}, 32'h0);
    chk("rst_we", {31'h0, ram_we_out}, 32'h0);
    rd("rst_ctrl", 7'h40, 8'h00);

    // Host writes into RAM with auto-increment
    host_wr(7'h41, 8'h10);
    host_wr(7'h42, 8'h00);
    host_wr(7'h43, 8'hA5);
    chk("wr0_we", {31'h0, ram_we_out}, 32'h1);
    chk("wr0_addr", {16'h0, ram_addr_out}, 32'h0010);
    chk("wr0_din", {24'h0, ram_din_out}, 32'hA5);
    host_wr(7'h43, 8'h5A);
    chk("wr1_we", {31'h0, ram_we_out}, 32'h1);
    chk("wr1_addr", {16'h0, ram_addr_out}, 32'h0011);
    chk("wr1_din", {24'h0, ram_din_out}, 32'h5A);
    ch.chanAddr_in = 7'h41;
    tick();
    chk("wr_we_pulse", {31'h0, ram_we_out}, 32'h0);
    rd("wr_ptr_lo", 7'h41, 8'h12);
    rd("wr_ptr_hi", 7'h42, 8'h00);
    chk("mem_0010", {24'h0, mem[16'h0010]}, 32'hA5);
    chk("mem_0011", {24'h0, mem[16'h0011]}, 32'h5A);

    // FSM reads: two-clock latency, consumption advances the pointer
    host_wr(7'h41, 8'h10);
    ch.chanAddr_in = 7'h43;
    #1 chk("rd_lat0", {31'h0, ch.f2hValid_out}, 32'h0);
    tick();
    chk("rd_lat1", {31'h0, ch.f2hValid_out}, 32'h0);
    tick();
    chk("rd0_valid", {31'h0, ch.f2hValid_out}, 32'h1);
    chk("rd0_data", {24'h0, ch.f2hData_out}, 32'hA5);
    ch.f2hReady_in = 1'b1;
    tick();
    ch.f2hReady_in = 1'b0;
    chk("rd1_lat0", {31'h0, ch.f2hValid_out}, 32'h0);
    tick();
    chk("rd1_lat1", {31'h0, ch.f2hValid_out}, 32'h0);
    tick();
    chk("rd1_valid", {31'h0, ch.f2hValid_out}, 32'h1);
    chk("rd1_data", {24'h0, ch.f2hData_out}, 32'h5A);
    ch.f2hReady_in = 1'b1;
    tick();
    ch.f2hReady_in = 1'b0;
    rd("rd_ptr_lo", 7'h41, 8'h12);

    // Pointer wrap on write at the top address
    host_wr(7'h41, 8'hFF);
    host_wr(7'h42, 8'hFF);
    host_wr(7'h43, 8'h77);
    chk("wrap_addr", {16'h0, ram_addr_out}, 32'hFFFF);
    chk("wrap_din", {24'h0, ram_din_out}, 32'h77);
    ch.chanAddr_in = 7'h41;
    tick();
    chk("mem_ffff", {24'h0, mem[16'hFFFF]}, 32'h77);
    rd("wrap_ptr_lo", 7'h41, 8'h00);
    rd("wrap_ptr_hi", 7'h42, 8'h00);

    // Single step with auto-snapshot, then coherent debug reads
    for (int k = 1; k < 8; k++) dbg_in[8*k +: 8] = 8'h10 + 8'(k);
    dbg_in[7:0] = 8'h3C;
    host_wr(7'h40, 8'h02);
    chk("step_pulse", {31'h0, cpu_step_out}, 32'h1);
    chk("step_led_before", {24'h0, led_out}, 32'h00);
    rd("step_ctrl", 7'h40, 8'h02);
    tick();
    chk("step_one_cycle", {31'h0, cpu_step_out}, 32'h0);
    chk("step_led", {24'h0, led_out}, 32'h3C);
    rd("snap_ch0", 7'h00, 8'h3C);
    rd("snap_ch1", 7'h01, 8'h11);
    dbg_in[15:8] = 8'hAB;
    rd("snap_coherent", 7'h01, 8'h11);
    host_wr(7'h40, 8'h04);
    chk("cap_no_step", {31'h0, cpu_step_out}, 32'h0);
    tick();
    rd("cap_ch1", 7'h01, 8'hAB);
    rd("cap_ch7", 7'h07, 8'h17);

    // No step when run is set by, or already set before, the write
    host_wr(7'h40, 8'h03);
    chk("step_run_after", {31'h0, cpu_step_out}, 32'h0);
    chk("run_set", {31'h0, cpu_run_out}, 32'h1);
    host_wr(7'h40, 8'h02);
    chk("step_run_before", {31'h0, cpu_step_out}, 32'h0);
    tick();
    chk("step_run_before2", {31'h0, cpu_step_out}, 32'h0);
    chk("run_cleared", {31'h0, cpu_run_out}, 32'h0);

    // Run set during a fetch aborts it and locks out RAM access
    host_wr(7'h41, 8'h10);
    host_wr(7'h42, 8'h00);
    ch.chanAddr_in = 7'h43;
    tick();
    rd("busy_ctrl", 7'h40, 8'h04);
    host_wr(7'h40, 8'h01);
    chk("run_sel", {31'h0, ram_host_sel_out}, 32'h0);
    rd("run_ctrl", 7'h40, 8'h01);
    rd("run_mem_ee", 7'h43, 8'hEE);
    chk("run_mem_valid", {31'h0, ch.f2hValid_out}, 32'h1);
    host_wr(7'h43, 8'h42);
    chk("run_no_we", {31'h0, ram_we_out}, 32'h0);
    tick();
    chk("run_no_we2", {31'h0, ram_we_out}, 32'h0);
    rd("run_ptr_kept", 7'h41, 8'h10);
    chk("run_mem_kept", {24'h0, mem[16'h0010]}, 32'hA5);
    host_wr(7'h40, 8'h00);
    chk("halt_sel", {31'h0, ram_host_sel_out}, 32'h1);

    // Unmapped channel reads zero and ignores writes
    rd("unmapped_rd", 7'h50, 8'h00);
    chk("unmapped_valid", {31'h0, ch.f2hValid_out}, 32'h1);
    host_wr(7'h50, 8'hFF);
    rd("unmapped_wr", 7'h41, 8'h10);

    // Reset coincident with a MEM_CH write: no RAM write, pointer cleared
    ch.chanAddr_in = 7'h43;
    ch.h2fData_in  = 8'h99;
    ch.h2fValid_in = 1'b1;
    reset          = 1'b1;
    tick();
    ch.h2fValid_in = 1'b0;
    reset          = 1'b0;
    chk("rst_mid_we", {31'h0, ram_we_out}, 32'h0);
    rd("rst_mid_ptr", 7'h41, 8'h00);
    tick();
    chk("rst_mid_mem", {24'h0, mem[16'h0010]}, 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chan_debug_bridge.md
Name: chan_debug_bridge

Overview:
- Bridges the comm_fpga_fx2 channel interface (chanAddr / h2f / f2h pipes) to the microprocessor and ram.
- Replaces the fixed 8-bit debug mux with a parametrised, register-mapped debug port. It provides:
  - NUM_DBG coherent snapshot bytes of CPU test signals;
  - run/halt/single-step control of the CPU;
  - auto-incrementing host access to program RAM while the CPU is halted.
- Sits in top_level between comm_fpga_fx2, the CPU and a RAM port mux driven by ram_host_sel_out.

Parameters:
NUM_DBG, 8, number of debug bytes in dbg_in; channels 0..NUM_DBG-1 (1..64)
ADDR_W, 16, RAM address width
CTRL_CH, 7'h40, control/status channel
ADDR_LO_CH, 7'h41, RAM pointer bits [7:0]
ADDR_HI_CH, 7'h42, RAM pointer bits [ADDR_W-1:8]
MEM_CH, 7'h43, RAM data window

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chanAddr_in  in  7  selected channel
h2fData_in  in  8  host write data
h2fValid_in  in  1  host write strobe
h2fReady_out  out  1  bridge accepts host data
f2hData_out  out  8  host read data
f2hValid_out  out  1  f2hData_out valid
f2hReady_in  in  1  host consumes f2hData_out this edge
dbg_in  in  NUM_DBG*8  flattened test signals, byte k = bits [8k+7:8k]
cpu_run_out  out  1  CPU clock enable (continuous run)
cpu_step_out  out  1  one-cycle CPU clock-enable pulse
ram_host_sel_out  out  1  1 = RAM port owned by this bridge
ram_addr_out  out  ADDR_W  RAM address (host side)
ram_din_out  out  8  RAM write data
ram_we_out  out  1  RAM write enable
ram_dout_in  in  8  RAM read data, valid one clk after address
led_out  out  8  snapshot byte 0

Behaviour:
Reset values:
- All outputs 0 except h2fReady_out=1.
- Snapshot, pointer and run cleared.
- Fetch FSM in IDLE.
- A reset mid-fetch or mid-step aborts the operation with no RAM write.

Host writes:
- Accepted on an edge with h2fValid_in=1. h2fReady_out is always 1.
- CTRL_CH:
  - bit0 sets run.
  - bit1 issues a one-cycle cpu_step_out on the next cycle, only if run=0 both before and after the write; otherwise ignored.
  - bit2 captures the snapshot on the next cycle.
- ADDR_LO_CH / ADDR_HI_CH: load the pointer halves.
- MEM_CH, run=0: ram_we_out=1 for exactly one cycle with ram_addr_out=ptr and ram_din_out=data. The pointer increments on the same edge as the write and wraps 2^ADDR_W-1 -> 0.
- MEM_CH, run=1: write is ignored; no ram_we_out, no increment.
- Writes to unmapped channels are ignored.

Snapshot:
- snap <= dbg_in, latched atomically on a bit2 capture.
- Also latched automatically one cycle after each cpu_step_out pulse.
- Debug channels read snap, never live dbg_in, so all bytes are coherent.

Host reads (combinational from registers unless noted):
- Channel k<NUM_DBG: f2hData_out=snap byte k, f2hValid_out=1.
- CTRL_CH: {5'b0, fsm_busy, step_pending, run}.
- ADDR_LO_CH / ADDR_HI_CH: pointer bytes.
- Unmapped channels: 8'h00, valid=1.
- MEM_CH with run=1: 8'hEE, valid=1.

MEM_CH read FSM (only while chanAddr_in==MEM_CH and run=0):
- IDLE: drive ram_addr_out=ptr; go FETCH; f2hValid_out=0.
- FETCH: on this edge, buf <= ram_dout_in; go VALID.
- VALID: f2hData_out=buf, f2hValid_out=1. On f2hReady_in=1: ptr++ (wrap) and go IDLE, which refetches.
- Latency: 2 clk from selection (or from consumption) to valid.
- Any of the following returns the FSM to IDLE with no increment, and a MEM_CH write suppresses the read consumption that cycle:
  - chanAddr_in change;
  - any pointer write or MEM_CH write;
  - run rising.
- Host write takes priority over read consumption in the same cycle.

Ownership:
- ram_host_sel_out = ~run.
- ram_we_out is never asserted while run=1.
- Setting run mid-fetch aborts the fetch.

Widths:
- Pointer halves: ADDR_HI_CH maps to the bits above 8. When ADDR_W<16, unused high bits are dropped on write and read as 0.

Test Plan:
- Reset, then read channel 3 and CTRL_CH -> f2hData_out=00; CTRL_CH reads 00; h2fReady_out=1; led_out=00.
- Write ADDR_LO=10, ADDR_HI=00, then MEM_CH bytes A5,5A -> ram_we_out pulses at 0x0010=A5 and 0x0011=5A; pointer reads 0x0012.
- Set ADDR=0x0010, select MEM_CH -> f2hValid_out low for 2 clk then A5; consume -> next value 5A after 2 clk; pointer advances to 0x0012.
- Set ADDR=0xFFFF, write MEM_CH 77 -> RAM[FFFF]=77; pointer wraps to 0x0000.
- dbg_in byte0=3C, CTRL write 02 with run=0 -> single cpu_step_out pulse; one cycle later snapshot byte0=3C and led_out=3C. The same write with run=1 -> no pulse.
- CTRL write 01 (run) during a MEM_CH fetch -> FSM aborts, ram_host_sel_out=0, MEM_CH reads EE, a MEM_CH write produces no ram_we_out.
